// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package router_pkg;

    localparam int ADDR_W    = 2;
    localparam int NUM_PORTS = 3;

    // Address value that no output port answers to; headers carrying it are dropped.
    localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

    // Packet sequencing states. The encoding fills all 3 bits, so every code is a legal state.
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        WAIT_TILL_EMPTY    = 3'd1,
        LOAD_FIRST_DATA    = 3'd2,
        LOAD_DATA          = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    // One-hot port mask for an address. The invalid address maps to no port.
    function automatic logic [NUM_PORTS-1:0] port_sel(input logic [ADDR_W-1:0] addr);
        logic [NUM_PORTS-1:0] sel;
        sel = '0;
        case (addr)
            2'd0:    sel = 3'b001;
            2'd1:    sel = 3'b010;
            2'd2:    sel = 3'b100;
            default: sel = 3'b000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/router_timeout.sv
// Per-port watchdog: flushes a destination that leaves valid data unread for TIMEOUT cycles.
// Latency: soft_reset rises one cycle after the TIMEOUT-th consecutive unread cycle; it lasts one cycle.
// Backpressure: none; it observes vld/rd only.
module router_timeout #(
    parameter int TIMEOUT = 30,
    parameter int TIMER_W = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;
    logic               pulse_q;
    logic               fire;

    // The last unread cycle before the limit triggers the flush.
    assign fire = vld && !rd && (cnt_q == TIMER_W'(TIMEOUT - 1));

    // Count consecutive unread cycles. Restart on a read, on an empty FIFO, or after firing.
    always_comb begin
        cnt_d = cnt_q;
        if (!vld || rd || fire) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + TIMER_W'(1);
        end
    end

    // Counter and single-cycle pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= fire;
        end
    end

    assign soft_reset = pulse_q;

endmodule

// File: rtl/router_ctrl.sv
// Packet sequencer for the 1x3 router: decodes the header, steers bytes to one FIFO, checks parity.
// Latency: header written 1 cycle after acceptance; payload written on the accepting edge.
// Backpressure: busy holds the source while waiting for empty/non-full FIFOs and during header/parity slots.
module router_ctrl
    import router_pkg::*;
#(
    parameter int TIMEOUT = 30,
    parameter int TIMER_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid,
    input  logic [7:0]           data_in,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] read_enb,
    output logic                 busy,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic [7:0]           data_to_fifo,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic [NUM_PORTS-1:0] vld_out,
    output logic [NUM_PORTS-1:0] soft_reset,
    output logic                 parity_err
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          hold_q, hold_d;
    logic [7:0]          calc_q, calc_d;
    logic [7:0]          pkt_par_q, pkt_par_d;
    logic                parity_err_q, parity_err_d;

    logic [ADDR_W-1:0]    hdr_addr;
    logic                 hdr_ok;
    logic                 hdr_dest_empty;
    logic [NUM_PORTS-1:0] sel_mask;
    logic                 sel_full;
    logic                 sel_empty;
    logic                 flush;

    assign vld_out    = ~fifo_empty;
    assign parity_err = parity_err_q;

    // Header decode and status of the currently selected port.
    assign hdr_addr       = data_in[ADDR_W-1:0];
    assign hdr_ok         = pkt_valid && (hdr_addr != INVALID_ADDR);
    assign hdr_dest_empty = |(fifo_empty & port_sel(hdr_addr));
    assign sel_mask       = port_sel(addr_q);
    assign sel_full       = |(fifo_full & sel_mask);
    assign sel_empty      = |(fifo_empty & sel_mask);

    // A flush of the port being written aborts the packet; the rest of it is treated as stray data.
    assign flush = (state_q != DECODE_ADDRESS) && |(soft_reset & sel_mask);

    // One timeout watchdog per output port.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_timeout
        router_timeout #(
            .TIMEOUT (TIMEOUT),
            .TIMER_W (TIMER_W)
        ) u_timeout (
            .clk        (clk),
            .rst        (rst),
            .vld        (vld_out[g]),
            .rd         (read_enb[g]),
            .soft_reset (soft_reset[g])
        );
    end

    // Next-state, datapath updates and Moore/steering outputs.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        hold_d       = hold_q;
        calc_d       = calc_q;
        pkt_par_d    = pkt_par_q;
        parity_err_d = parity_err_q;
        busy         = 1'b1;
        lfd_state    = 1'b0;
        ld_state     = 1'b0;
        write_enb    = '0;
        data_to_fifo = hold_q;

        case (state_q)
            DECODE_ADDRESS: begin
                busy = 1'b0;
                if (hdr_ok) begin
                    addr_d       = hdr_addr;
                    hold_d       = data_in;
                    parity_err_d = 1'b0;
                    state_d      = hdr_dest_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end

            WAIT_TILL_EMPTY: begin
                if (sel_empty) begin
                    state_d = LOAD_FIRST_DATA;
                end
            end

            LOAD_FIRST_DATA: begin
                lfd_state = 1'b1;
                write_enb = sel_mask;
                calc_d    = hold_q;
                state_d   = LOAD_DATA;
            end

            LOAD_DATA: begin
                busy         = 1'b0;
                ld_state     = 1'b1;
                data_to_fifo = data_in;
                if (!pkt_valid) begin
                    // Parity byte: always taken here; a full FIFO is absorbed in LOAD_PARITY.
                    hold_d    = data_in;
                    pkt_par_d = data_in;
                    state_d   = LOAD_PARITY;
                end else if (!sel_full) begin
                    write_enb = sel_mask;
                    calc_d    = calc_q ^ data_in;
                end else begin
                    hold_d  = data_in;
                    state_d = FIFO_FULL_STATE;
                end
            end

            FIFO_FULL_STATE: begin
                if (!sel_full) begin
                    state_d = LOAD_AFTER_FULL;
                end
            end

            LOAD_AFTER_FULL: begin
                write_enb = sel_mask;
                calc_d    = calc_q ^ hold_q;
                state_d   = LOAD_DATA;
            end

            LOAD_PARITY: begin
                // The received parity is stored in the FIFO but never folded into the running XOR.
                if (!sel_full) begin
                    write_enb = sel_mask;
                    state_d   = CHECK_PARITY_ERROR;
                end
            end

            CHECK_PARITY_ERROR: begin
                parity_err_d = (calc_q != pkt_par_q);
                state_d      = DECODE_ADDRESS;
            end

            default: begin
                state_d = DECODE_ADDRESS;
            end
        endcase

        // A port flush overrides every transition and suppresses the write into the flushed FIFO.
        if (flush) begin
            state_d      = DECODE_ADDRESS;
            write_enb    = '0;
            hold_d       = hold_q;
            calc_d       = calc_q;
            pkt_par_d    = pkt_par_q;
            parity_err_d = parity_err_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= DECODE_ADDRESS;
            addr_q       <= '0;
            hold_q       <= '0;
            calc_q       <= '0;
            pkt_par_q    <= '0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            hold_q       <= hold_d;
            calc_q       <= calc_d;
            pkt_par_q    <= pkt_par_d;
            parity_err_q <= parity_err_d;
        end
    end

endmodule

// File: tb/tb_router_ctrl.sv
// Directed bench for router_ctrl: packet sequencing, stalls, parity, timeouts and resets.
// Latency: inputs driven 1 ns after the rising edge, outputs sampled 1-2 ns after it.
// Backpressure: the bench plays the source and honours busy by holding its byte.
module tb_router_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] read_enb;
    logic       busy;
    logic [2:0] write_enb;
    logic [7:0] data_to_fifo;
    logic       lfd_state;
    logic       ld_state;
    logic [2:0] vld_out;
    logic [2:0] soft_reset;
    logic       parity_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] par;

    router_ctrl #(
        .TIMEOUT (30),
        .TIMER_W (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .read_enb     (read_enb),
        .busy         (busy),
        .write_enb    (write_enb),
        .data_to_fifo (data_to_fifo),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .vld_out      (vld_out),
        .soft_reset   (soft_reset),
        .parity_err   (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Unstalled 3-byte packet from DECODE back to DECODE, checking every write slot.
    task automatic pkt3(input logic [7:0] hdr, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] pbyte, input logic [2:0] wsel);
        logic [7:0] pl [3];
        pl = '{b0, b1, b2};
        pkt_valid = 1'b1;
        data_in   = hdr;
        #1;
        chk("hdr_busy", busy, 0);
        chk("hdr_we", write_enb, 0);
        tick();
        data_in = b0;
        #1;
        chk("lfd_we", write_enb, wsel);
        chk("lfd_dat", data_to_fifo, hdr);
        chk("lfd_state", lfd_state, 1);
        chk("lfd_busy", busy, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            data_in = pl[i];
            #1;
            chk("ld_we", write_enb, wsel);
            chk("ld_dat", data_to_fifo, pl[i]);
            chk("ld_state", ld_state, 1);
            chk("ld_lfd", lfd_state, 0);
            chk("ld_busy", busy, 0);
            tick();
        end
        pkt_valid = 1'b0;
        data_in   = pbyte;
        #1;
        chk("parbyte_we", write_enb, 0);
        chk("parbyte_ld", ld_state, 1);
        tick();
        chk("lp_we", write_enb, wsel);
        chk("lp_dat", data_to_fifo, pbyte);
        chk("lp_busy", busy, 1);
        tick();
        chk("cpe_we", write_enb, 0);
        chk("cpe_busy", busy, 1);
        tick();
        chk("end_busy", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        pkt_valid  = 1'b0;
        data_in    = 8'h00;
        fifo_full  = 3'b000;
        fifo_empty = 3'b111;
        read_enb   = 3'b000;
        tick();
        tick();
        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_we", write_enb, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_sr", soft_reset, 0);
        chk("rst_lfd", lfd_state, 0);
        chk("rst_ld", ld_state, 0);
        chk("rst_vld", vld_out, 0);
        rst = 1'b0;
        tick();

        // Invalid address 3 is dropped and DECODE is kept
        pkt_valid = 1'b1;
        data_in   = 8'h07;
        #1;
        chk("inv_we", write_enb, 0);
        tick();
        pkt_valid = 1'b0;
        #1;
        chk("inv_busy", busy, 0);
        chk("inv_lfd", lfd_state, 0);
        chk("inv_we2", write_enb, 0);
        tick();

        // Clean packet to port 1: parity is the XOR of header and payload
        par = 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33;
        pkt3(8'h0D, 8'h11, 8'h22, 8'h33, par, 3'b010);
        chk("clean_perr", parity_err, 0);

        // Same packet with a wrong parity byte
        pkt3(8'h0D, 8'h11, 8'h22, 8'h33, 8'h00, 3'b010);
        chk("bad_perr", parity_err, 1);

        // Port 0 packet with a full stall on the 2nd payload byte, then a full parity slot
        pkt_valid = 1'b1;
        data_in   = 8'h0C;
        tick();
        chk("perr_clear", parity_err, 0);
        data_in = 8'hA1;
        #1;
        chk("fs_lfd_we", write_enb, 3'b001);
        tick();
        #1;
        chk("fs_b0_we", write_enb, 3'b001);
        chk("fs_b0_dat", data_to_fifo, 8'hA1);
        tick();
        data_in   = 8'hB2;
        fifo_full = 3'b001;
        #1;
        chk("fs_full_we", write_enb, 0);
        chk("fs_full_ld", ld_state, 1);
        tick();
        data_in = 8'hC3;
        #1;
        chk("ffs_busy", busy, 1);
        chk("ffs_we", write_enb, 0);
        tick();
        chk("ffs_busy2", busy, 1);
        fifo_full = 3'b000;
        #1;
        chk("ffs_we2", write_enb, 0);
        tick();
        chk("laf_we", write_enb, 3'b001);
        chk("laf_dat", data_to_fifo, 8'hB2);
        chk("laf_busy", busy, 1);
        tick();
        chk("fs_b2_we", write_enb, 3'b001);
        chk("fs_b2_dat", data_to_fifo, 8'hC3);
        chk("fs_b2_busy", busy, 0);
        tick();
        par       = 8'h0C ^ 8'hA1 ^ 8'hB2 ^ 8'hC3;
        pkt_valid = 1'b0;
        data_in   = par;
        fifo_full = 3'b001;
        #1;
        chk("fs_par_we", write_enb, 0);
        tick();
        chk("lp_full_busy", busy, 1);
        chk("lp_full_we", write_enb, 0);
        tick();
        chk("lp_full_we2", write_enb, 0);
        fifo_full = 3'b000;
        #1;
        chk("lp_we_p0", write_enb, 3'b001);
        chk("lp_dat_p0", data_to_fifo, par);
        tick();
        tick();
        chk("fs_perr", parity_err, 0);
        chk("fs_end_busy", busy, 0);

        // Header to a port whose FIFO is still draining
        fifo_empty = 3'b011;
        pkt_valid  = 1'b1;
        data_in    = 8'h0E;
        tick();
        chk("wait_busy", busy, 1);
        chk("wait_we", write_enb, 0);
        data_in = 8'h55;
        tick();
        chk("wait_busy2", busy, 1);
        fifo_empty = 3'b111;
        #1;
        chk("wait_we2", write_enb, 0);
        tick();
        chk("wait_lfd_we", write_enb, 3'b100);
        chk("wait_lfd_dat", data_to_fifo, 8'h0E);
        tick();
        chk("wait_b0_we", write_enb, 3'b100);
        tick();
        pkt_valid = 1'b0;
        data_in   = 8'h0E ^ 8'h55;
        tick();
        chk("wait_lp_we", write_enb, 3'b100);
        tick();
        tick();
        chk("wait_perr", parity_err, 0);

        // Timeout on port 0: pulse after 30 unread cycles, single cycle wide
        fifo_empty = 3'b110;
        #1;
        chk("to_vld", vld_out, 3'b001);
        for (int i = 1; i <= 29; i++) begin
            tick();
            chk("to_quiet", soft_reset, 0);
        end
        tick();
        chk("to_fire", soft_reset, 3'b001);
        tick();
        chk("to_once", soft_reset, 0);

        // A read in cycle 29 restarts the count
        fifo_empty = 3'b111;
        tick();
        fifo_empty = 3'b110;
        for (int i = 1; i <= 28; i++) begin
            tick();
            chk("rd_quiet", soft_reset, 0);
        end
        read_enb = 3'b001;
        tick();
        chk("rd_nofire", soft_reset, 0);
        read_enb = 3'b000;
        for (int i = 1; i <= 29; i++) begin
            tick();
            chk("rd_quiet2", soft_reset, 0);
        end
        tick();
        chk("rd_refire", soft_reset, 3'b001);
        fifo_empty = 3'b111;
        tick();
        chk("rd_done", soft_reset, 0);

        // Soft reset of the selected port aborts a packet stuck in WAIT_TILL_EMPTY
        fifo_empty = 3'b110;
        pkt_valid  = 1'b1;
        data_in    = 8'h0C;
        tick();
        pkt_valid = 1'b0;
        chk("sr_wait_busy", busy, 1);
        for (int i = 2; i <= 29; i++) begin
            tick();
            chk("sr_wait_hold", busy, 1);
        end
        tick();
        chk("sr_pulse", soft_reset, 3'b001);
        chk("sr_pulse_busy", busy, 1);
        tick();
        chk("sr_abort_busy", busy, 0);
        chk("sr_abort_lfd", lfd_state, 0);
        fifo_empty = 3'b111;
        tick();

        // Reset in the middle of LOAD_DATA
        pkt_valid = 1'b1;
        data_in   = 8'h0D;
        tick();
        data_in = 8'h11;
        tick();
        chk("mid_ld", ld_state, 1);
        data_in = 8'h22;
        rst     = 1'b1;
        tick();
        rst       = 1'b0;
        pkt_valid = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_we", write_enb, 0);
        chk("mid_rst_ld", ld_state, 0);
        chk("mid_rst_lfd", lfd_state, 0);
        chk("mid_rst_perr", parity_err, 0);
        chk("mid_rst_sr", soft_reset, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
